dmem_arbiter: RTL

//  Shares the single-port DataMemory between the CPU MEM stage and a DMA requester (UART/display

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: the CPU MEM-stage port, the DMA burst port and
// the DataMemory port.
//   slave  : the arbiter's view. Requests and mem_rdata come in; grants, stall,
//            returned data and the memory command go out.
//   master : the surrounding system's view, with every direction reversed.
// LEN_W sets the width of dma_len. A burst is dma_len+1 words.
interface dmem_arbiter_if #(
    parameter int LEN_W = 4
);
    // CPU MEM stage
    logic             cpu_rd;
    logic             cpu_wr;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_stall;
    // DMA requester
    logic             dma_req;
    logic             dma_wr;
    logic [31:0]      dma_addr;
    logic [LEN_W-1:0] dma_len;
    logic [31:0]      dma_wdata;
    logic             dma_gnt;
    logic             dma_valid;
    logic [31:0]      dma_rdata;
    logic             dma_done;
    // DataMemory
    logic             mem_rd;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_wr, dma_addr, dma_len, dma_wdata,
        output dma_gnt, dma_valid, dma_rdata, dma_done,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_wr, dma_addr, dma_len, dma_wdata,
        input  dma_gnt, dma_valid, dma_rdata, dma_done,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets the CPU MEM stage and a DMA burst engine share one
// single-port DataMemory.
// The CPU has priority and passes straight through while the arbiter is idle.
// The DMA gets fixed-length word bursts of dma_len+1 beats. A wait counter
// forces the DMA onto the bus after MAX_WAIT blocked cycles. While a burst owns
// the bus, cpu_stall follows the CPU's request.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : dmem_arbiter_if.slave (CPU, DMA and DataMemory signals)
// Parameters:
//   MAX_WAIT : blocked idle cycles before the DMA is forced in (>= 1)
//   LEN_W    : width of dma_len
module dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int LEN_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    // The counter only has to reach MAX_WAIT-1.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       base_q, base_d;
    logic              wr_q, wr_d;

    logic        cpu_busy;
    logic        mem_rd, mem_wr, dma_gnt, dma_valid, dma_done, cpu_stall;
    logic [31:0] mem_addr, mem_wdata, cpu_rdata, dma_rdata;

    assign cpu_busy = bus.cpu_rd | bus.cpu_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            base_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            base_q     <= base_d;
            wr_q       <= wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        len_d      = len_q;
        base_d     = base_q;
        wr_d       = wr_q;

        // The CPU owns the bus unless a burst is running.
        mem_rd     = bus.cpu_rd;
        mem_wr     = bus.cpu_wr;
        mem_addr   = bus.cpu_addr;
        mem_wdata  = bus.cpu_wdata;
        cpu_rdata  = bus.mem_rdata;
        cpu_stall  = 1'b0;
        dma_gnt    = 1'b0;
        dma_valid  = 1'b0;
        dma_rdata  = '0;
        dma_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.dma_req) begin
                    if (!cpu_busy || wait_cnt_q == WAIT_LAST) begin
                        base_d     = bus.dma_addr;
                        len_d      = bus.dma_len;
                        wr_d       = bus.dma_wr;
                        beat_d     = '0;
                        wait_cnt_d = '0;
                        state_d    = ST_BURST;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_BURST: begin
                dma_gnt   = 1'b1;
                dma_valid = 1'b1;
                cpu_stall = cpu_busy;
                cpu_rdata = '0;
                // Word-align the base, then step by whole words. The 32-bit
                // add wraps naturally past 0xFFFFFFFC.
                mem_addr  = (base_q & 32'hFFFF_FFFC) + (32'(beat_q) << 2);
                mem_rd    = ~wr_q;
                // Suppress the write in a reset cycle, so an interrupted burst
                // commits nothing more.
                mem_wr    = wr_q & ~reset;
                mem_wdata = bus.dma_wdata;
                dma_rdata = bus.mem_rdata;
                if (beat_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: begin
                // One cycle handback. A still-asserted dma_req is looked at
                // again in IDLE.
                dma_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.cpu_stall = cpu_stall;
    assign bus.dma_gnt   = dma_gnt;
    assign bus.dma_valid = dma_valid;
    assign bus.dma_rdata = dma_rdata;
    assign bus.dma_done  = dma_done;
endmodule
